// File: rtl/sobel_gradient_3x3.sv
// -----------------------------------------------------------------------------
// sobel_gradient_3x3
//
// Computes the Sobel gradient magnitude (|Gx| + |Gy|, shifted and saturated to
// 16 bits) and a 2-bit quantised gradient direction from an 8-bit 3x3 window.
// Free-running 4-stage pipeline; frame sync signals are delayed by the same
// 4 clk so they stay aligned with the data.
//
// Optional feature: define GRAD_LOW_THRESH_EN to zero magnitude and direction
// whenever the saturated magnitude is below LOW_THRESH.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   per_frame_vsync/href/clken window-aligned frame sync and pixel valid
//   matrix_p11..matrix_p33     3x3 window (row 1 top, column 1 left)
//   post_frame_vsync/href/clken sync signals delayed by 4 clk
//   post_grad_mag              gradient magnitude (0 during href blanking)
//   post_grad_dir              0: horizontal gradient, 1: 45 deg,
//                              2: vertical gradient, 3: 135 deg
// -----------------------------------------------------------------------------
module sobel_gradient_3x3 #(
    parameter int unsigned MAG_SHIFT  = 0,
    parameter logic [15:0] LOW_THRESH = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  matrix_p11,
    input  logic [7:0]  matrix_p12,
    input  logic [7:0]  matrix_p13,
    input  logic [7:0]  matrix_p21,
    input  logic [7:0]  matrix_p22,
    input  logic [7:0]  matrix_p23,
    input  logic [7:0]  matrix_p31,
    input  logic [7:0]  matrix_p32,
    input  logic [7:0]  matrix_p33,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [15:0] post_grad_mag,
    output logic [1:0]  post_grad_dir
);

    // Largest raw magnitude that still fits in 16 bits after the shift.
    localparam logic [15:0] MagLimit = 16'hFFFF >> MAG_SHIFT;

    // a + 2*b + c, all unsigned; max 1020 fits 10 bits.
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return 10'(a) + {1'b0, b, 1'b0} + 10'(c);
    endfunction

    // Centre pixel does not contribute to either kernel.
    logic unused_p22;
    assign unused_p22 = ^matrix_p22;

    // ---------------------------------------------------------------- sync lines
    logic [3:0] vsync_q, href_q, clken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= '0;
            href_q  <= '0;
            clken_q <= '0;
        end else begin
            vsync_q <= {vsync_q[2:0], per_frame_vsync};
            href_q  <= {href_q[2:0], per_frame_href};
            clken_q <= {clken_q[2:0], per_frame_clken};
        end
    end

    assign post_frame_vsync = vsync_q[3];
    assign post_frame_href  = href_q[3];
    assign post_frame_clken = clken_q[3];

    // ---------------------------------------------------------------- S1
    logic [9:0] xp_q, xn_q, yp_q, yn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xp_q <= '0;
            xn_q <= '0;
            yp_q <= '0;
            yn_q <= '0;
        end else begin
            xp_q <= wsum(matrix_p13, matrix_p23, matrix_p33);
            xn_q <= wsum(matrix_p11, matrix_p21, matrix_p31);
            yp_q <= wsum(matrix_p31, matrix_p32, matrix_p33);
            yn_q <= wsum(matrix_p11, matrix_p12, matrix_p13);
        end
    end

    // ---------------------------------------------------------------- S2
    logic signed [10:0] gx_d, gy_d, gx_q, gy_q;

    always_comb begin
        gx_d = $signed({1'b0, xp_q}) - $signed({1'b0, xn_q});
        gy_d = $signed({1'b0, yp_q}) - $signed({1'b0, yn_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_q <= '0;
            gy_q <= '0;
        end else begin
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    // ---------------------------------------------------------------- S3
    logic [9:0]  ax, ay;
    // ax*309 reaches 315180, so the compare runs at 19 bits to avoid overflow.
    logic [18:0] py, p53, p309;
    logic [10:0] m_d, m_q;
    logic        lt_d, gt_d, same_d;
    logic        lt_q, gt_q, same_q;

    always_comb begin
        ax     = gx_q[10] ? 10'(-gx_q) : gx_q[9:0];
        ay     = gy_q[10] ? 10'(-gy_q) : gy_q[9:0];
        m_d    = {1'b0, ax} + {1'b0, ay};
        py     = {2'b00, ay, 7'b0000000};
        p53    = 19'(ax) * 19'd53;
        p309   = 19'(ax) * 19'd309;
        // A zero gradient is forced into class 0 rather than falling to diagonal.
        lt_d   = (py < p53) || ((ax == '0) && (ay == '0));
        gt_d   = py > p309;
        same_d = gx_q[10] == gy_q[10];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= '0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            same_q <= 1'b0;
        end else begin
            m_q    <= m_d;
            lt_q   <= lt_d;
            gt_q   <= gt_d;
            same_q <= same_d;
        end
    end

    // ---------------------------------------------------------------- S4
    logic [15:0] mag_sat, mag_d;
    logic [1:0]  dir_d;

    always_comb begin
        mag_sat = ({5'b00000, m_q} > MagLimit) ? 16'hFFFF
                                               : 16'({5'b00000, m_q} << MAG_SHIFT);
        if (lt_q) begin
            dir_d = 2'd0;
        end else if (gt_q) begin
            dir_d = 2'd2;
        end else if (same_q) begin
            dir_d = 2'd1;
        end else begin
            dir_d = 2'd3;
        end
        mag_d = mag_sat;
`ifdef GRAD_LOW_THRESH_EN
        if (mag_sat < LOW_THRESH) begin
            mag_d = '0;
            dir_d = 2'd0;
        end
`endif
        // href as it enters S4 is the one aligned with this data.
        if (!href_q[2]) begin
            mag_d = '0;
            dir_d = 2'd0;
        end
    end

`ifndef GRAD_LOW_THRESH_EN
    logic unused_low_thresh;
    assign unused_low_thresh = ^LOW_THRESH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_grad_mag <= '0;
            post_grad_dir <= '0;
        end else begin
            post_grad_mag <= mag_d;
            post_grad_dir <= dir_d;
        end
    end

endmodule

// File: tb/tb_sobel_gradient_3x3.sv
module tb_sobel_gradient_3x3;

    typedef logic [8:0][7:0] win_t;  // index 0 = p11, 1 = p12, ... 8 = p33

    typedef struct {
        logic vs, hs, ce;
        int   m0, d0, m6, d6, m7, d7;
    } exp_t;

    typedef struct {
        win_t w;
        int   mag;
        int   dir;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic vs_in, hs_in, ce_in;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

    logic v0, h0, c0, v6, h6, c6, v7, h7, c7;
    logic [15:0] mag0, mag6, mag7;
    logic [1:0]  dir0, dir6, dir7;

    int n_checks = 0;
    int n_err    = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    sobel_gradient_3x3 #(.MAG_SHIFT(0), .LOW_THRESH(16'd100)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs_in), .per_frame_href(hs_in), .per_frame_clken(ce_in),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .post_frame_vsync(v0), .post_frame_href(h0), .post_frame_clken(c0),
        .post_grad_mag(mag0), .post_grad_dir(dir0)
    );

    sobel_gradient_3x3 #(.MAG_SHIFT(6), .LOW_THRESH(16'd100)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs_in), .per_frame_href(hs_in), .per_frame_clken(ce_in),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .post_frame_vsync(v6), .post_frame_href(h6), .post_frame_clken(c6),
        .post_grad_mag(mag6), .post_grad_dir(dir6)
    );

    sobel_gradient_3x3 #(.MAG_SHIFT(7), .LOW_THRESH(16'd100)) u_dut7 (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs_in), .per_frame_href(hs_in), .per_frame_clken(ce_in),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .post_frame_vsync(v7), .post_frame_href(h7), .post_frame_clken(c7),
        .post_grad_mag(mag7), .post_grad_dir(dir7)
    );

    // ------------------------------------------------------------ reference model
    function automatic win_t mkwin(input int a11, input int a12, input int a13,
                                   input int a21, input int a22, input int a23,
                                   input int a31, input int a32, input int a33);
        win_t w;
        w[0] = 8'(a11); w[1] = 8'(a12); w[2] = 8'(a13);
        w[3] = 8'(a21); w[4] = 8'(a22); w[5] = 8'(a23);
        w[6] = 8'(a31); w[7] = 8'(a32); w[8] = 8'(a33);
        return w;
    endfunction

    // Convolve the window with the two Sobel kernels.
    function automatic void sobel(input win_t w, output int gx, output int gy);
        int kx[9];
        int ky[9];
        kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        gx = 0;
        gy = 0;
        for (int i = 0; i < 9; i++) begin
            gx += kx[i] * int'(w[i]);
            gy += ky[i] * int'(w[i]);
        end
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Sector classification via tan(22.5) ~ 53/128 and tan(67.5) ~ 309/128.
    function automatic int dir_of(input int gx, input int gy);
        int ax, ay;
        ax = iabs(gx);
        ay = iabs(gy);
        if (ax == 0 && ay == 0) return 0;
        if (ay * 128 < ax * 53) return 0;
        if (ay * 128 > ax * 309) return 2;
        if ((gx >= 0) == (gy >= 0)) return 1;
        return 3;
    endfunction

    function automatic int sat(input int m, input int sh);
        longint v;
        v = longint'(m) <<< sh;
        return (v > 65535) ? 65535 : int'(v);
    endfunction

    function automatic void post(input int raw, input int d, input int sh, input logic hs,
                                 output int mo, output int dout);
        mo   = sat(raw, sh);
        dout = d;
`ifdef GRAD_LOW_THRESH_EN
        if (mo < 100) begin
            mo   = 0;
            dout = 0;
        end
`endif
        if (!hs) begin
            mo   = 0;
            dout = 0;
        end
    endfunction

    function automatic exp_t make_exp(input logic vs, input logic hs, input logic ce,
                                      input int raw, input int d);
        exp_t e;
        e.vs = vs;
        e.hs = hs;
        e.ce = ce;
        post(raw, d, 0, hs, e.m0, e.d0);
        post(raw, d, 6, hs, e.m6, e.d6);
        post(raw, d, 7, hs, e.m7, e.d7);
        return e;
    endfunction

    // ------------------------------------------------------------ stimulus helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic reset_queue();
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(make_exp(1'b0, 1'b0, 1'b0, 0, 0));
    endtask

    task automatic set_win(input win_t w);
        p11 = w[0]; p12 = w[1]; p13 = w[2];
        p21 = w[3]; p22 = w[4]; p23 = w[5];
        p31 = w[6]; p32 = w[7]; p33 = w[8];
    endtask

    // Drive a window and queue the model's expectation.
    task automatic drive_model(input logic vs, input logic hs, input logic ce, input win_t w);
        int gx, gy;
        vs_in = vs;
        hs_in = hs;
        ce_in = ce;
        set_win(w);
        sobel(w, gx, gy);
        exp_q.push_back(make_exp(vs, hs, ce, iabs(gx) + iabs(gy), dir_of(gx, gy)));
    endtask

    // Drive a window with a hand-computed expectation.
    task automatic drive_const(input win_t w, input int mag, input int dir);
        vs_in = 1'b1;
        hs_in = 1'b1;
        ce_in = 1'b1;
        set_win(w);
        exp_q.push_back(make_exp(1'b1, 1'b1, 1'b1, mag, dir));
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("sync", {29'd0, v0, h0, c0}, {29'd0, e.vs, e.hs, e.ce});
            check("sync_s67", {26'd0, v6, h6, c6, v7, h7, c7},
                  {26'd0, e.vs, e.hs, e.ce, e.vs, e.hs, e.ce});
            check("mag0", 32'(mag0), 32'(e.m0));
            check("dir0", 32'(dir0), 32'(e.d0));
            check("mag6", 32'(mag6), 32'(e.m6));
            check("dir6", 32'(dir6), 32'(e.d6));
            check("mag7", 32'(mag7), 32'(e.m7));
            check("dir7", 32'(dir7), 32'(e.d7));
        end
        if (h0 === 1'b0) check("blank", {14'd0, mag0, dir0}, 32'd0);
    endtask

    task automatic check_zero(input string name);
        check(name, {23'd0, v0, h0, c0, 1'b0, dir0, dir6, dir7},  32'd0);
        check(name, {mag0, mag6 | mag7}, 32'd0);
    endtask

    function automatic win_t rand_win();
        win_t w;
        for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 3) == 0) w[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
            else w[i] = 8'($urandom_range(0, 255));
        end
        return w;
    endfunction

    // ------------------------------------------------------------ test
    vec_t vecs[12];

    initial begin
        vecs[0]  = '{mkwin(0, 128, 255, 0, 128, 255, 0, 128, 255), 1020, 0};  // vertical edge
        vecs[1]  = '{mkwin(0, 0, 0, 128, 128, 128, 255, 255, 255), 1020, 2};  // horizontal
        vecs[2]  = '{mkwin(255, 255, 255, 128, 128, 128, 0, 0, 0), 1020, 2};  // inverted
        vecs[3]  = '{mkwin(0, 0, 255, 0, 255, 255, 255, 255, 255), 1530, 1};  // 45 deg
        vecs[4]  = '{mkwin(255, 0, 0, 255, 255, 0, 255, 255, 255), 1530, 3};  // 135 deg
        vecs[5]  = '{mkwin(128, 128, 128, 128, 128, 128, 128, 128, 128), 0, 0};  // flat
        vecs[6]  = '{mkwin(0, 0, 20, 0, 0, 20, 0, 0, 20), 80, 0};
        vecs[7]  = '{mkwin(0, 0, 30, 0, 0, 30, 0, 0, 30), 120, 0};
        vecs[8]  = '{mkwin(0, 0, 0, 0, 0, 128, 0, 53, 0), 362, 1};      // tie at 53: diagonal
        vecs[9]  = '{mkwin(0, 0, 0, 0, 0, 128, 0, 52, 0), 360, 0};      // just below
        vecs[10] = '{mkwin(0, 0, 0, 0, 0, 128, 54, 255, 54), 874, 1};   // tie at 309: diagonal
        vecs[11] = '{mkwin(0, 0, 0, 0, 0, 128, 55, 255, 55), 876, 2};   // just above

        rst_n = 1'b0;
        vs_in = 1'b0;
        hs_in = 1'b0;
        ce_in = 1'b0;
        set_win(mkwin(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        reset_queue();

        // Directed table, back to back.
        for (int i = 0; i < 12; i++) begin
            drive_const(vecs[i].w, vecs[i].mag, vecs[i].dir);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive_model(1'b0, 1'b0, 1'b0, rand_win());
            tick();
        end

        // 10-clk href pulse, alternating clken, inside a vsync frame, then short pulses.
        for (int i = 0; i < 24; i++) begin
            logic vs, hs, ce;
            vs = (i >= 1) && (i <= 14);
            hs = (i >= 3) && (i <= 12);
            ce = hs && (i % 2 == 1);
            if (i == 17 || i == 19 || i == 20) begin
                hs = 1'b1;
                ce = 1'b1;
            end
            drive_model(vs, hs, ce, rand_win());
            tick();
        end

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_model(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 1)), rand_win());
            tick();
        end

        // Reset asserted mid-line.
        for (int i = 0; i < 6; i++) begin
            drive_model(1'b1, 1'b1, 1'b1, rand_win());
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset_immediate");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_zero("reset_held");
        end
        rst_n = 1'b1;
        reset_queue();
        for (int i = 0; i < 20; i++) begin
            drive_model(1'b1, 1'b1, 1'b1, rand_win());
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
